// File: rtl/led_key_pkg.sv
// Shared mode encoding and LED decode for led_key_ctrl.
// The BLINK code is always defined here; only led_key_ctrl decides whether it is reachable.
package led_key_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 3'd0,
        MODE_L0    = 3'd1,
        MODE_L1    = 3'd2,
        MODE_BOTH  = 3'd3,
        MODE_BLINK = 3'd4
    } mode_e;

    localparam mode_e MODE_LAST_NOBLINK = MODE_BOTH;
    localparam mode_e MODE_LAST_BLINK   = MODE_BLINK;

    // Static LED pattern {led1, led0} for a mode; BLINK yields its entry pattern.
    function automatic logic [1:0] led_decode(input mode_e m);
        logic [1:0] leds;
        leds = 2'b00;
        case (m)
            MODE_L0:    leds = 2'b01;
            MODE_L1:    leds = 2'b10;
            MODE_BOTH:  leds = 2'b11;
            MODE_BLINK: leds = 2'b01;
            default:    leds = 2'b00;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes, debounces and edge-detects one active-low push-button.
// A key held through reset is ignored until it has been seen released.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            fill_q  <= 2'd0;
            cnt_q   <= '0;
            db_q    <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        cnt_d   = '0;
        db_d    = db_q;
        // Count consecutive cycles of disagreement; any agreeing cycle restarts.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Arm only once the synchronizer carries real samples showing a released key.
        armed_d = armed_q | ((fill_q == 2'd2) & sync_q[1] & db_q);
        press_d = armed_q & db_q & ~db_d;
    end

    assign press = press_q;

endmodule

// File: rtl/led_key_ctrl.sv
// Two-key LED mode controller: key0 steps forward, key1 steps back, both return to OFF.
// Define LED_KEY_CTRL_BLINK_EN to add the BLINK mode and its half-period counter.
module led_key_ctrl
    import led_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned BLINK_HALF_CYCLES = 12500000
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              key0,
    input  logic              key1,
    output logic              led0,
    output logic              led1,
    output logic [MODE_W-1:0] mode
);

`ifdef LED_KEY_CTRL_BLINK_EN
    localparam mode_e MODE_LAST = MODE_LAST_BLINK;
    localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 2) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF_CYCLES - 1);
`else
    localparam mode_e MODE_LAST = MODE_LAST_NOBLINK;
`endif

    logic  press0, press1;
    mode_e mode_q, mode_d;
    logic  led0_q, led0_d;
    logic  led1_q, led1_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk   (sysclk),
        .rst_n (rst_n),
        .key_n (key0),
        .press (press0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk   (sysclk),
        .rst_n (rst_n),
        .key_n (key1),
        .press (press1)
    );

`ifdef LED_KEY_CTRL_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
            led0_q <= 1'b0;
            led1_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led0_q <= led0_d;
            led1_q <= led1_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        case ({press1, press0})
            2'b11: mode_d = MODE_OFF;
            2'b01: mode_d = (mode_q == MODE_LAST) ? MODE_OFF
                          : mode_e'(MODE_W'(mode_q) + MODE_W'(1));
            2'b10: mode_d = (mode_q == MODE_OFF) ? MODE_LAST
                          : mode_e'(MODE_W'(mode_q) - MODE_W'(1));
            default: mode_d = mode_q;
        endcase

        // LEDs follow the next mode so they change on the same edge as mode.
        {led1_d, led0_d} = led_decode(mode_d);

`ifdef LED_KEY_CTRL_BLINK_EN
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        // Staying in BLINK: run the half-period counter; entry uses the static 1/0 pattern.
        if (mode_d == MODE_BLINK && mode_q == MODE_BLINK) begin
            phase_d = phase_q;
            if (blink_cnt_q == BLINK_MAX) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
            led0_d = ~phase_d;
            led1_d = phase_d;
        end
`endif
    end

    assign mode = MODE_W'(mode_q);
    assign led0 = led0_q;
    assign led1 = led1_q;

endmodule

// File: tb/tb_led_key_ctrl.sv
// Directed bench for led_key_ctrl with DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8.
// Define LED_KEY_CTRL_BLINK_EN for both bench and RTL to exercise the BLINK mode.
module tb_led_key_ctrl;

    logic       sysclk;
    logic       rst_n;
    logic       key0;
    logic       key1;
    logic       led0;
    logic       led1;
    logic [2:0] mode;

    int total;
    int bad;

`ifdef LED_KEY_CTRL_BLINK_EN
    localparam logic [2:0] LAST = 3'd4;
`else
    localparam logic [2:0] LAST = 3'd3;
`endif

    led_key_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .BLINK_HALF_CYCLES (8)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .key0   (key0),
        .key1   (key1),
        .led0   (led0),
        .led1   (led1),
        .mode   (mode)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Press the selected keys for hold cycles, release, then let the release debounce settle.
    task automatic press(input logic p0, input logic p1, input int hold);
        @(negedge sysclk);
        key0 = ~p0;
        key1 = ~p1;
        repeat (hold) @(negedge sysclk);
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (14) @(negedge sysclk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key0  = 1'b1;
        key1  = 1'b1;
        repeat (3) @(negedge sysclk);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        total++;
        if ({led1, led0} !== 2'b00) begin bad++; $display("FAIL reset_leds got=%b exp=00", {led1, led0}); end
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL idle_mode got=%0d exp=0", mode); end
    endtask

    task automatic test_debounce;
        press(1'b1, 1'b0, 3);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL short_glitch got=%0d exp=0", mode); end
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd1) begin bad++; $display("FAIL debounced_step got=%0d exp=1", mode); end
        total++;
        if ({led1, led0} !== 2'b01) begin bad++; $display("FAIL l0_leds got=%b exp=01", {led1, led0}); end
    endtask

    task automatic test_wrap;
        press(1'b0, 1'b1, 10);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL back_to_off got=%0d exp=0", mode); end
        press(1'b0, 1'b1, 10);
        total++;
        if (mode !== LAST) begin bad++; $display("FAIL wrap_back got=%0d exp=%0d", mode, LAST); end
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL wrap_fwd got=%0d exp=0", mode); end
        total++;
        if ({led1, led0} !== 2'b00) begin bad++; $display("FAIL off_leds got=%b exp=00", {led1, led0}); end
    endtask

    task automatic test_simultaneous;
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd2) begin bad++; $display("FAIL to_l1 got=%0d exp=2", mode); end
        total++;
        if ({led1, led0} !== 2'b10) begin bad++; $display("FAIL l1_leds got=%b exp=10", {led1, led0}); end
        press(1'b1, 1'b1, 10);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL both_keys got=%0d exp=0", mode); end
        total++;
        if ({led1, led0} !== 2'b00) begin bad++; $display("FAIL both_keys_leds got=%b exp=00", {led1, led0}); end
    endtask

    task automatic test_held;
        @(negedge sysclk);
        key0 = 1'b0;
        repeat (100) @(negedge sysclk);
        total++;
        if (mode !== 3'd1) begin bad++; $display("FAIL held_one_step got=%0d exp=1", mode); end
        key0 = 1'b1;
        repeat (14) @(negedge sysclk);
        total++;
        if (mode !== 3'd1) begin bad++; $display("FAIL release_no_step got=%0d exp=1", mode); end
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd2) begin bad++; $display("FAIL repress_step got=%0d exp=2", mode); end
    endtask

    task automatic test_async_reset;
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd3) begin bad++; $display("FAIL to_both got=%0d exp=3", mode); end
        total++;
        if ({led1, led0} !== 2'b11) begin bad++; $display("FAIL both_leds got=%b exp=11", {led1, led0}); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL async_rst_mode got=%0d exp=0", mode); end
        total++;
        if ({led1, led0} !== 2'b00) begin bad++; $display("FAIL async_rst_leds got=%b exp=00", {led1, led0}); end
    endtask

    task automatic test_held_through_reset;
        @(negedge sysclk);
        key0 = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (20) @(negedge sysclk);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL held_rst_no_press got=%0d exp=0", mode); end
        key0 = 1'b1;
        repeat (14) @(negedge sysclk);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL held_rst_release got=%0d exp=0", mode); end
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd1) begin bad++; $display("FAIL after_held_rst got=%0d exp=1", mode); end
    endtask

`ifdef LED_KEY_CTRL_BLINK_EN
    task automatic test_blink;
        int  waited;
        logic [1:0] exp_leds;
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        @(negedge sysclk);
        key0   = 1'b0;
        waited = 0;
        while (mode !== 3'd4 && waited < 40) begin
            @(negedge sysclk);
            waited++;
        end
        total++;
        if (mode !== 3'd4) begin bad++; $display("FAIL blink_enter got=%0d exp=4", mode); end
        // First sample is the cycle right after the entry edge.
        for (int c = 0; c < 24; c++) begin
            exp_leds = ((c / 8) % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if ({led1, led0} !== exp_leds) begin
                bad++;
                $display("FAIL blink_cycle%0d got=%b exp=%b", c, {led1, led0}, exp_leds);
            end
            @(negedge sysclk);
        end
        key0 = 1'b1;
        repeat (14) @(negedge sysclk);
        total++;
        if (mode !== 3'd4) begin bad++; $display("FAIL blink_hold_release got=%0d exp=4", mode); end
        press(1'b1, 1'b0, 10);
        total++;
        if (mode !== 3'd0) begin bad++; $display("FAIL blink_exit got=%0d exp=0", mode); end
        total++;
        if ({led1, led0} !== 2'b00) begin bad++; $display("FAIL blink_exit_leds got=%b exp=00", {led1, led0}); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_debounce;
        test_wrap;
        test_simultaneous;
        test_held;
        test_async_reset;
        test_held_through_reset;
`ifdef LED_KEY_CTRL_BLINK_EN
        test_blink;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
